lcd_spi_write: RTL
==================

// Module: lcd_spi_write
// PURPOSE
//  SPI byte transmitter for the ST7735 LCD. It consumes the 9-bit {dc,byte} stream
//  from lcd_init (and later pixel sources) under en_write.
//  Each word is serialized MSB-first on a 4-wire SPI link in mode 0 (CPOL=0, CPHA=0).
//  One wr_done pulse per byte tells the producer to advance its pointer.
// PARAMETERS
//  CLK_DIV    2  sys_clk cycles per SCLK half-period (>=1); 50MHz/4 = 12.5MHz SCLK
//  SETUP_CYC  2  cycles waited before latching data (>=2; producer updates data 2 cycles after wr_done)
//  CS_HOLD    1  cycles lcd_cs stays low after the last SCLK falling edge (>=1)
// PORTS
//  sys_clk    in   1  system clock; the only clock
//  sys_rst_n  in   1  asynchronous, active-low reset
//  en_write   in   1  producer has a word to send; level, held for the whole sequence
//  init_data  in   9  [8]=1 data / 0 command; [7:0] byte; must be stable from latch to wr_done
//  wr_done    out  1  one-cycle pulse: current byte fully shifted out
//  lcd_sclk   out  1  SPI clock; idles low
//  lcd_mosi   out  1  SPI data, MSB first
//  lcd_dc     out  1  D/C line; copy of the latched init_data[8]
//  lcd_cs     out  1  chip select, active low
// BEHAVIOUR
//  Reset: every output is registered. Values in reset: lcd_cs=1, lcd_sclk=0, lcd_mosi=0,
//   lcd_dc=0, wr_done=0, FSM=IDLE, all counters 0.
//  FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
//  IDLE:  lcd_cs=1, lcd_sclk=0. If en_write=1, go to SETUP on the next cycle.
//  SETUP: count SETUP_CYC cycles. On the last count:
//   - latch init_data into an 8-bit shift register and lcd_dc
//   - drive lcd_mosi=init_data[7] and lcd_cs=0
//   - go to SHIFT.
//  SHIFT: 8 bits. Each bit is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
//   - SCLK rises at the low->high phase change; the LCD samples on that edge.
//   - At each falling edge, shift left and drive lcd_mosi with the next bit.
//   - After the 8th high phase, sclk returns to 0 and the FSM goes to HOLD.
//  HOLD: sclk=0, lcd_cs stays 0 for CS_HOLD cycles, then go to DONE.
//  DONE: one cycle with wr_done=1 and lcd_cs=1.
//   - Next state is SETUP if en_write=1, else IDLE.
//   - CS is therefore high for >= SETUP_CYC+1 cycles between bytes.
//  Latency: SETUP entry to wr_done = SETUP_CYC + 16*CLK_DIV + CS_HOLD + 1 cycles
//   (36 cycles with defaults).
//  Boundaries:
//   - en_write falls mid-byte: finish the byte, still pulse wr_done, return to IDLE.
//   - en_write falls during SETUP (before latch): abort to IDLE; no bytes, no wr_done.
//   - init_data changes after latch: ignored until the next SETUP.
//   - DATA_IDLE (9'h100) is transmitted like any word, as data byte 0x00.
//   - Async reset mid-byte: outputs return to reset values at once; the byte is lost
//     and no wr_done is issued.
//  Widths: div counter $clog2(CLK_DIV+1); bit counter 3 bits; setup/hold counters
//   sized from their parameters. Counters saturate at the terminal value, never wrap.
// STRUCTURE
//  Shared package lcd_pkg:
//   - FSM state localparams (one-hot, 5 bits)
//   - DATA_IDLE = 9'h100
//   - DC_BIT = 8
//   - the init_data width (9)
//  Single module; no sub-module. The SCLK divider is an inline counter gated by the SHIFT state.
// TESTING
//  1. Word 9'h0_11, en_write pulse held:
//     - dc=0; mosi bits 0,0,0,1,0,0,0,1 sampled on 8 SCLK rises
//     - wr_done 36 cycles after SETUP entry
//  2. Word 9'h1_A5, then en_write low before DONE:
//     - dc=1; bits 1,0,1,0,0,1,0,1
//     - one wr_done, then IDLE with cs=1
//  3. Back-to-back stream modelling lcd_init (B1,01,2C,2D):
//     - producer updates data 2 cycles after each wr_done
//     - all 4 bytes transmitted in order
//     - cs high >= 3 cycles between bytes
//  4. sys_rst_n pulled low during bit 4:
//     - cs=1, sclk=0, mosi=0 within the reset assertion
//     - no wr_done
//     - after release, the next en_write sends a full byte
//  5. en_write dropped during SETUP: no SCLK edges, no wr_done, cs stays 1.
//  6. CLK_DIV=1, word 9'h1_FF:
//     - SCLK period 2 cycles, mosi held at 1 for all 8 bits
//     - wr_done 20 cycles after SETUP entry

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7735 LCD datapath: word format and SPI writer states.
package lcd_pkg;

    localparam int DATA_W = 9;
    localparam int DC_BIT = 8;
    localparam logic [DATA_W-1:0] DATA_IDLE = 9'h100;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_SETUP = 5'b00010,
        ST_SHIFT = 5'b00100,
        ST_HOLD  = 5'b01000,
        ST_DONE  = 5'b10000
    } state_t;

endpackage

// File: rtl/lcd_spi_write.sv
// SPI mode-0 byte transmitter for the ST7735: serializes {dc,byte} words MSB-first
// and pulses wr_done once per byte so the producer can advance.
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int SETUP_CYC = 2,
    parameter int CS_HOLD   = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en_write,
    input  logic [DATA_W-1:0] init_data,
    output logic              wr_done,
    output logic              lcd_sclk,
    output logic              lcd_mosi,
    output logic              lcd_dc,
    output logic              lcd_cs
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int SET_W = $clog2(SETUP_CYC + 1);
    localparam int HLD_W = $clog2(CS_HOLD + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYC - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(CS_HOLD - 1);

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [SET_W-1:0] set_q;
    logic [HLD_W-1:0] hld_q;
    logic [2:0]       bit_q;
    logic [7:0]       sr_q;
    logic             sclk_q;
    logic             dc_q;
    logic             cs_q;
    logic             done_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            set_q   <= '0;
            hld_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            sclk_q  <= 1'b0;
            dc_q    <= 1'b0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cs_q   <= 1'b1;
                    sclk_q <= 1'b0;
                    set_q  <= '0;
                    if (en_write) state_q <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (!en_write) begin
                        set_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (set_q == SET_LAST) begin
                        sr_q    <= init_data[7:0];
                        dc_q    <= init_data[DC_BIT];
                        cs_q    <= 1'b0;
                        sclk_q  <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
                        set_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        set_q <= set_q + SET_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        // falling edge: present the next bit, or finish after bit 7
                        if (sclk_q) begin
                            if (bit_q == 3'd7) begin
                                hld_q   <= '0;
                                state_q <= ST_HOLD;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                sr_q  <= {sr_q[6:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (hld_q == HLD_LAST) begin
                        done_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        hld_q <= hld_q + HLD_W'(1);
                    end
                end
                ST_DONE: begin
                    set_q   <= '0;
                    state_q <= en_write ? ST_SETUP : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // MSB of the shift register drives MOSI directly, keeping it a registered output
    assign lcd_mosi = sr_q[7];
    assign lcd_sclk = sclk_q;
    assign lcd_dc   = dc_q;
    assign lcd_cs   = cs_q;
    assign wr_done  = done_q;

endmodule
